sram_like_arbiter: RTL and testbench

- Shares one SRAM-like slave port between the instruction and data SRAM-like masters; the slave port feeds the AXI bridge.
- Grants one master per cycle and forwards that master's request fields to the slave.
- Records the owner of every accepted request in an in-order tag FIFO.
- Routes each data_ok/rdata response back to the master that issued the request.

---
 rtl/sram_like_arbiter.sv | 141 ++++++++++++++
 tb/tb_sram_like_arbiter.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/sram_like_arbiter.sv
// Shares one SRAM-like slave port between the inst and data masters and routes responses
// back through an in-order owner-tag FIFO. Define ARB_ROUND_ROBIN_EN for round-robin arbitration.
module sram_like_arbiter #(
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        i_req,
  input  logic        i_wr,
  input  logic [1:0]  i_size,
  input  logic [31:0] i_addr,
  input  logic [3:0]  i_wstrb,
  input  logic [31:0] i_wdata,
  output logic        i_addr_ok,
  output logic        i_data_ok,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_wr,
  input  logic [1:0]  d_size,
  input  logic [31:0] d_addr,
  input  logic [3:0]  d_wstrb,
  input  logic [31:0] d_wdata,
  output logic        d_addr_ok,
  output logic        d_data_ok,
  output logic [31:0] d_rdata,
  output logic        s_req,
  output logic        s_wr,
  output logic [1:0]  s_size,
  output logic [31:0] s_addr,
  output logic [3:0]  s_wstrb,
  output logic [31:0] s_wdata,
  input  logic        s_addr_ok,
  input  logic        s_data_ok,
  input  logic [31:0] s_rdata,
  output logic        busy,
  output logic        err_orphan
);

  localparam int PW = $clog2(MAX_OUTSTANDING);
  localparam logic [PW:0] DEPTH = (PW+1)'(MAX_OUTSTANDING);

  logic [PW-1:0]              wr_ptr, rd_ptr;
  logic [PW:0]                count;
  logic [MAX_OUTSTANDING-1:0] owner_mem;
  logic                       lock_valid, lock_owner, err_q;
  logic                       full, empty, gnt_valid, gnt_owner, push, pop, head_owner;

  assign full  = (count == DEPTH);
  assign empty = (count == '0);

`ifdef ARB_ROUND_ROBIN_EN
  logic rr_last;

  always_ff @(posedge aclk) begin
    if (!aresetn) rr_last <= 1'b0;
    else if (push) rr_last <= gnt_owner;
  end
`endif

  // Owner encoding: 0 = inst, 1 = data. A locked request keeps the port even when full.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_owner = 1'b0;
    if (aresetn) begin
      if (lock_valid) begin
        gnt_valid = 1'b1;
        gnt_owner = lock_owner;
      end else if (!full) begin
`ifdef ARB_ROUND_ROBIN_EN
        if (d_req && i_req) begin
          gnt_valid = 1'b1;
          gnt_owner = ~rr_last;
        end else if (d_req) begin
`else
        if (d_req) begin
`endif
          gnt_valid = 1'b1;
          gnt_owner = 1'b1;
        end else if (i_req) begin
          gnt_valid = 1'b1;
          gnt_owner = 1'b0;
        end
      end
    end
  end

  assign s_req   = gnt_valid & (gnt_owner ? d_req : i_req);
  assign s_wr    = gnt_valid & (gnt_owner ? d_wr : i_wr);
  assign s_size  = gnt_valid ? (gnt_owner ? d_size  : i_size)  : 2'b00;
  assign s_addr  = gnt_valid ? (gnt_owner ? d_addr  : i_addr)  : 32'h0;
  assign s_wstrb = gnt_valid ? (gnt_owner ? d_wstrb : i_wstrb) : 4'h0;
  assign s_wdata = gnt_valid ? (gnt_owner ? d_wdata : i_wdata) : 32'h0;

  assign push       = s_req & s_addr_ok;
  assign pop        = aresetn & s_data_ok & ~empty;
  assign head_owner = owner_mem[rd_ptr];

  assign i_addr_ok = push & ~gnt_owner;
  assign d_addr_ok = push & gnt_owner;
  assign i_data_ok = pop & ~head_owner;
  assign d_data_ok = pop & head_owner;
  assign i_rdata   = s_rdata;
  assign d_rdata   = s_rdata;

  assign busy       = (count != '0) | lock_valid;
  assign err_orphan = err_q;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      owner_mem  <= '0;
      lock_valid <= 1'b0;
      lock_owner <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      if (push) begin
        owner_mem[wr_ptr] <= gnt_owner;
        wr_ptr            <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
      lock_valid <= s_req & ~s_addr_ok;
      if (s_req & ~s_addr_ok) lock_owner <= gnt_owner;
      if (s_data_ok & empty) err_q <= 1'b1;
    end
  end

`ifndef SYNTHESIS
  // Grants are never issued unlocked while full, so an overflowing push means a broken lock.
  always_ff @(posedge aclk) begin
    if (aresetn) assert (!(push && full && !pop));
  end
`endif

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Bench for sram_like_arbiter: directed test-plan steps, then random traffic, all checked
// every cycle against a queue-based reference model.
module tb_sram_like_arbiter;

  localparam int MO = 4;

  logic        aclk = 1'b0, aresetn = 1'b0;
  logic        i_req = 0, i_wr = 0, d_req = 0, d_wr = 0;
  logic [1:0]  i_size = 0, d_size = 0, s_size;
  logic [31:0] i_addr = 0, i_wdata = 0, d_addr = 0, d_wdata = 0;
  logic [3:0]  i_wstrb = 0, d_wstrb = 0, s_wstrb;
  logic        i_addr_ok, i_data_ok, d_addr_ok, d_data_ok;
  logic [31:0] i_rdata, d_rdata, s_addr, s_wdata;
  logic        s_req, s_wr, busy, err_orphan;
  logic        s_addr_ok = 0, s_data_ok = 0;
  logic [31:0] s_rdata = 0;

  int n_cmp = 0, n_bad = 0;

  bit mq[$];
  bit m_lock_v, m_lock_o, m_rr, m_err;

  sram_like_arbiter #(.MAX_OUTSTANDING(MO)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .i_req(i_req), .i_wr(i_wr), .i_size(i_size), .i_addr(i_addr), .i_wstrb(i_wstrb),
    .i_wdata(i_wdata), .i_addr_ok(i_addr_ok), .i_data_ok(i_data_ok), .i_rdata(i_rdata),
    .d_req(d_req), .d_wr(d_wr), .d_size(d_size), .d_addr(d_addr), .d_wstrb(d_wstrb),
    .d_wdata(d_wdata), .d_addr_ok(d_addr_ok), .d_data_ok(d_data_ok), .d_rdata(d_rdata),
    .s_req(s_req), .s_wr(s_wr), .s_size(s_size), .s_addr(s_addr), .s_wstrb(s_wstrb),
    .s_wdata(s_wdata), .s_addr_ok(s_addr_ok), .s_data_ok(s_data_ok), .s_rdata(s_rdata),
    .busy(busy), .err_orphan(err_orphan)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Owner: 0 = inst, 1 = data.
  function automatic void exp_grant(output bit gv, output bit go);
    gv = 1'b0;
    go = 1'b0;
    if (!aresetn) return;
    if (m_lock_v) begin
      gv = 1'b1;
      go = m_lock_o;
    end else if (mq.size() < MO) begin
      if (d_req && i_req) begin
        gv = 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
        go = !m_rr;
`else
        go = 1'b1;
`endif
      end else if (d_req) begin
        gv = 1'b1;
        go = 1'b1;
      end else if (i_req) begin
        gv = 1'b1;
        go = 1'b0;
      end
    end
  endfunction

  // Check every output mid-cycle, then advance the model at the clock edge.
  task automatic cycle();
    bit gv, go, esreq, push, pop, head, e_wr;
    logic [1:0]  e_size;
    logic [3:0]  e_wstrb;
    logic [31:0] e_addr, e_wdata;
    @(negedge aclk);
    exp_grant(gv, go);
    esreq   = gv && (go ? d_req : i_req);
    e_wr    = gv && (go ? d_wr : i_wr);
    e_size  = gv ? (go ? d_size : i_size) : 2'd0;
    e_addr  = gv ? (go ? d_addr : i_addr) : 32'd0;
    e_wstrb = gv ? (go ? d_wstrb : i_wstrb) : 4'd0;
    e_wdata = gv ? (go ? d_wdata : i_wdata) : 32'd0;
    push    = esreq && s_addr_ok;
    pop     = aresetn && s_data_ok && (mq.size() != 0);
    head    = pop ? mq[0] : 1'b0;
    chk("s_req", 32'(s_req), 32'(esreq));
    chk("s_ctl", 32'({s_wr, s_size, s_wstrb}), 32'({e_wr, e_size, e_wstrb}));
    chk("s_addr", s_addr, e_addr);
    chk("s_wdata", s_wdata, e_wdata);
    chk("addr_ok", 32'({i_addr_ok, d_addr_ok}), 32'({push && !go, push && go}));
    chk("data_ok", 32'({i_data_ok, d_data_ok}), 32'({pop && !head, pop && head}));
    chk("rdata", 32'(i_rdata ^ d_rdata ^ s_rdata), s_rdata);
    chk("busy", 32'(busy), 32'(mq.size() != 0 || m_lock_v));
    chk("err_orphan", 32'(err_orphan), 32'(m_err));
    @(posedge aclk);
    if (!aresetn) begin
      mq.delete();
      m_lock_v = 0; m_lock_o = 0; m_rr = 0; m_err = 0;
    end else begin
      if (s_data_ok && mq.size() == 0) m_err = 1;
      if (pop) void'(mq.pop_front());
      if (push) begin
        mq.push_back(go);
        m_rr = go;
      end
      m_lock_v = esreq && !s_addr_ok;
      m_lock_o = go;
    end
    #1;
  endtask

  initial begin
    @(posedge aclk); #1;
    cycle(); cycle();
    aresetn = 1;
    #1 chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_s_req", 32'(s_req), 32'd0);

    // contention
    i_addr = 32'h0000_1000; d_addr = 32'h0000_2000;
    i_req = 1; d_req = 1; s_addr_ok = 1;
    for (int k = 0; k < 4; k++) begin
`ifdef ARB_ROUND_ROBIN_EN
      #1 chk("contend_addr", s_addr, (k % 2 == 0) ? 32'h0000_2000 : 32'h0000_1000);
`else
      #1 chk("contend_addr", s_addr, 32'h0000_2000);
`endif
      cycle();
    end
    i_req = 0; d_req = 0; s_addr_ok = 0; s_data_ok = 1;
    repeat (4) cycle();
    s_data_ok = 0;

    // single read
    d_req = 1; d_wr = 0; d_addr = 32'h1C00_0100; s_addr_ok = 1;
    #1 chk("read_addr_ok", 32'(d_addr_ok), 32'd1);
    cycle();
    d_req = 0; s_addr_ok = 0;
    cycle();
    s_data_ok = 1; s_rdata = 32'hDEAD_BEEF;
    #1 chk("read_data_ok", 32'({i_data_ok, d_data_ok}), 32'b01);
    chk("read_rdata", d_rdata, 32'hDEAD_BEEF);
    cycle();
    s_data_ok = 0;

    // lock
    i_req = 1; i_addr = 32'h0000_0A00; d_addr = 32'h0000_0B00;
    for (int k = 0; k < 3; k++) begin
      if (k == 1) d_req = 1;
      #1 chk("lock_addr", s_addr, 32'h0000_0A00);
      chk("lock_no_ok", 32'({i_addr_ok, d_addr_ok}), 32'b00);
      cycle();
    end
    s_addr_ok = 1;
    #1 chk("lock_i_ok", 32'({i_addr_ok, d_addr_ok}), 32'b10);
    chk("lock_addr_acc", s_addr, 32'h0000_0A00);
    cycle();
    #1 chk("lock_d_next", 32'({i_addr_ok, d_addr_ok}), 32'b01);
    cycle();
    i_req = 0; d_req = 0; s_addr_ok = 0; s_data_ok = 1;
    repeat (2) cycle();
    s_data_ok = 0;

    // full
    d_req = 1; s_addr_ok = 1;
    repeat (4) cycle();
    #1 chk("full_s_req", 32'(s_req), 32'd0);
    chk("full_d_ok", 32'(d_addr_ok), 32'd0);
    cycle();
    s_data_ok = 1;
    cycle();
    s_data_ok = 0;
    #1 chk("full_regrant", 32'(d_addr_ok), 32'd1);
    cycle();
    d_req = 0; s_addr_ok = 0; s_data_ok = 1;
    repeat (4) cycle();
    s_data_ok = 0;

    // interleaved routing
    s_addr_ok = 1;
    i_req = 1; cycle();
    i_req = 0; d_req = 1; cycle();
    d_req = 0; i_req = 1; cycle();
    i_req = 0; s_addr_ok = 0; s_data_ok = 1;
    s_rdata = 32'h11;
    #1 chk("route1", 32'({i_data_ok, d_data_ok, i_rdata[7:0]}), 32'h211);
    cycle();
    s_rdata = 32'h22;
    #1 chk("route2", 32'({i_data_ok, d_data_ok, d_rdata[7:0]}), 32'h122);
    cycle();
    s_rdata = 32'h33;
    #1 chk("route3", 32'({i_data_ok, d_data_ok, i_rdata[7:0]}), 32'h233);
    cycle();

    // orphan and reset
    #1 chk("orphan_no_ok", 32'({i_data_ok, d_data_ok}), 32'b00);
    cycle();
    s_data_ok = 0;
    #1 chk("orphan_flag", 32'(err_orphan), 32'd1);
    cycle();
    aresetn = 0;
    cycle();
    aresetn = 1;
    #1 chk("post_rst_err", 32'(err_orphan), 32'd0);
    chk("post_rst_busy", 32'(busy), 32'd0);

    // random traffic with one mid-run reset
    for (int k = 0; k < 400; k++) begin
      aresetn   = (k != 200);
      i_req     = 1'($urandom_range(0, 1));
      d_req     = 1'($urandom_range(0, 1));
      i_wr      = 1'($urandom_range(0, 1));
      d_wr      = 1'($urandom_range(0, 1));
      i_size    = 2'($urandom_range(0, 3));
      d_size    = 2'($urandom_range(0, 3));
      i_addr    = $urandom;
      d_addr    = $urandom;
      i_wstrb   = 4'($urandom_range(0, 15));
      d_wstrb   = 4'($urandom_range(0, 15));
      i_wdata   = $urandom;
      d_wdata   = $urandom;
      s_addr_ok = 1'($urandom_range(0, 1));
      s_data_ok = (mq.size() != 0) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 15) == 0);
      s_rdata   = $urandom;
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
